// File: rtl/core_pkg.sv
// Shared core types: aligner state encoding and the RVC length-decode helper.
package core_pkg;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_WORD_LO = 2'd1,
        S_WORD_HI = 2'd2
    } aligner_state_t;

    // A halfword starts a 16-bit instruction unless both low bits are set.
    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_aligner.sv
// Turns a stream of word-aligned fetch words into aligned 16/32-bit instructions,
// including 32-bit instructions that straddle two fetch words.
module instr_aligner
    import core_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_compressed_o,
    output logic [31:0] pc_o
);

    aligner_state_t state_reg, state_next;
    logic [31:0]    buffer_reg, buffer_next;
    logic [31:0]    pc_reg, pc_next;
    logic [15:0]    active_half;
    logic           active_compressed;
    logic           fetch_hs;
    logic           instr_hs;

    assign active_half       = (state_reg == S_WORD_HI) ? buffer_reg[31:16] : buffer_reg[15:0];
    assign active_compressed = is_compressed(active_half);

    // Outputs: a new word is only accepted when this cycle's instruction drains the buffer.
    always_comb begin : output_logic
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_o       = '0;
        unique case (state_reg)
            S_EMPTY: begin
                fetch_ready_o = 1'b1;
            end
            S_WORD_LO: begin
                instr_valid_o = 1'b1;
                if (active_compressed) begin
                    instr_o = {16'h0000, active_half};
                end else begin
                    instr_o       = buffer_reg;
                    fetch_ready_o = instr_ready_i;
                end
            end
            S_WORD_HI: begin
                fetch_ready_o = instr_ready_i;
                if (active_compressed) begin
                    instr_valid_o = 1'b1;
                    instr_o       = {16'h0000, active_half};
                end else begin
                    // Straddle: upper half of the instruction is still on the fetch bus.
                    instr_valid_o = fetch_valid_i;
                    instr_o       = {fetch_rdata_i[15:0], active_half};
                end
            end
            default: begin
                instr_valid_o = 1'b0;
            end
        endcase
        if (flush_i || !rst_n_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

    assign fetch_hs = fetch_valid_i & fetch_ready_o;
    assign instr_hs = instr_valid_o & instr_ready_i;

    always_comb begin : next_state_logic
        state_next  = state_reg;
        buffer_next = buffer_reg;
        pc_next     = pc_reg;
        if (flush_i) begin
            state_next = S_EMPTY;
            pc_next    = {flush_pc_i[31:1], 1'b0};
        end else begin
            if (fetch_hs) begin
                buffer_next = fetch_rdata_i;
            end
            unique case (state_reg)
                S_EMPTY: begin
                    if (fetch_hs) begin
                        state_next = pc_reg[1] ? S_WORD_HI : S_WORD_LO;
                    end
                end
                S_WORD_LO: begin
                    if (instr_hs) begin
                        if (active_compressed) begin
                            pc_next    = pc_reg + 32'd2;
                            state_next = S_WORD_HI;
                        end else begin
                            pc_next    = pc_reg + 32'd4;
                            state_next = fetch_hs ? S_WORD_LO : S_EMPTY;
                        end
                    end
                end
                S_WORD_HI: begin
                    if (instr_hs) begin
                        if (active_compressed) begin
                            pc_next    = pc_reg + 32'd2;
                            state_next = fetch_hs ? S_WORD_LO : S_EMPTY;
                        end else begin
                            // Straddle completes; the new word's upper half becomes active.
                            pc_next    = pc_reg + 32'd4;
                            state_next = S_WORD_HI;
                        end
                    end
                end
                default: begin
                    state_next = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= S_EMPTY;
            buffer_reg <= '0;
            pc_reg     <= BOOT_ADDR;
        end else begin
            state_reg  <= state_next;
            buffer_reg <= buffer_next;
            pc_reg     <= pc_next;
        end
    end

    assign pc_o               = pc_reg;
    assign instr_compressed_o = instr_o[1:0] != 2'b11;

endmodule
